// File: rtl/lcd_bus_arbiter.sv
// HD44780-style character LCD bus owner: power-on init sequence, then
// round-robin service of two byte requesters with all bus timing derived from CLK.
module lcd_bus_arbiter #(
    parameter int PWRUP_CYC    = 750000,
    parameter int SETUP_CYC    = 3,
    parameter int EN_HIGH_CYC  = 12,
    parameter int EXEC_CYC     = 5000,
    parameter int LONG_CYC     = 80000,
    parameter int INIT_GAP_CYC = 205000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       busy,
    output logic       init_done,
    output logic       LCD_RS,
    output logic       LCD_EN,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    // state | meaning
    // PWRUP | power-on delay before the first init write
    // SETUP | RS/DATA driven, EN low
    // PULSE | EN high
    // WAIT  | EN low, LCD executing the byte
    // IDLE  | init complete, arbitrating requesters
    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_WAIT  = 3'd3,
        S_IDLE  = 3'd4
    } state_t;

    // Every phase loads its length minus one and ends on terminal count zero.
    localparam logic [19:0] PWRUP_M1 = 20'(PWRUP_CYC - 1);
    localparam logic [19:0] SETUP_M1 = 20'(SETUP_CYC - 1);
    localparam logic [19:0] EN_M1    = 20'(EN_HIGH_CYC - 1);
    localparam logic [19:0] EXEC_M1  = 20'(EXEC_CYC - 1);
    localparam logic [19:0] LONG_M1  = 20'(LONG_CYC - 1);
    localparam logic [19:0] GAP_M1   = 20'(INIT_GAP_CYC - 1);

    state_t      state, state_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic [2:0]  init_idx, init_idx_nxt;
    logic        init_done_q, init_done_nxt;
    logic        rr_last, rr_last_nxt;
    logic        rs_q, rs_nxt;
    logic [7:0]  data_q, data_nxt;
    logic        long_q, long_nxt;
    logic        en_q;
    logic        cnt_tc;
    logic        idle_open;
    logic        grant0, grant1;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0, 3'd1, 3'd2: b = 8'h30;
            3'd3:             b = 8'h38;
            3'd4:             b = 8'h08;
            3'd5:             b = 8'h01;
            3'd6:             b = 8'h06;
            default:          b = 8'h0C;
        endcase
        return b;
    endfunction

    function automatic logic [19:0] init_wait(input logic [2:0] idx);
        logic [19:0] w;
        if (idx == 3'd0)
            w = GAP_M1;
        else if (idx == 3'd5)
            w = LONG_M1;
        else
            w = EXEC_M1;
        return w;
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return !rs && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
    endfunction

    assign cnt_tc    = (cnt == 20'd0);
    assign idle_open = (state == S_IDLE) && init_done_q;

    // Both valid: favour whichever requester was not served last.
    assign grant0 = idle_open && req0_valid && (!req1_valid || rr_last);
    assign grant1 = idle_open && req1_valid && (!req0_valid || !rr_last);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt_tc ? cnt : cnt - 20'd1;
        init_idx_nxt  = init_idx;
        init_done_nxt = init_done_q;
        rr_last_nxt   = rr_last;
        rs_nxt        = rs_q;
        data_nxt      = data_q;
        long_nxt      = long_q;

        case (state)
            S_PWRUP: begin
                if (cnt_tc) begin
                    state_nxt    = S_SETUP;
                    cnt_nxt      = SETUP_M1;
                    init_idx_nxt = 3'd0;
                    rs_nxt       = 1'b0;
                    data_nxt     = init_byte(3'd0);
                end
            end
            S_SETUP: begin
                if (cnt_tc) begin
                    state_nxt = S_PULSE;
                    cnt_nxt   = EN_M1;
                end
            end
            S_PULSE: begin
                if (cnt_tc) begin
                    state_nxt = S_WAIT;
                    if (!init_done_q)
                        cnt_nxt = init_wait(init_idx);
                    else
                        cnt_nxt = long_q ? LONG_M1 : EXEC_M1;
                end
            end
            S_WAIT: begin
                if (cnt_tc) begin
                    if (init_done_q) begin
                        state_nxt = S_IDLE;
                    end else if (init_idx == 3'd7) begin
                        state_nxt     = S_IDLE;
                        init_done_nxt = 1'b1;
                    end else begin
                        state_nxt    = S_SETUP;
                        cnt_nxt      = SETUP_M1;
                        init_idx_nxt = init_idx + 3'd1;
                        rs_nxt       = 1'b0;
                        data_nxt     = init_byte(init_idx + 3'd1);
                    end
                end
            end
            S_IDLE: begin
                if (grant0) begin
                    state_nxt   = S_SETUP;
                    cnt_nxt     = SETUP_M1;
                    rr_last_nxt = 1'b0;
                    rs_nxt      = req0_rs;
                    data_nxt    = req0_data;
                    long_nxt    = is_long_cmd(req0_rs, req0_data);
                end else if (grant1) begin
                    state_nxt   = S_SETUP;
                    cnt_nxt     = SETUP_M1;
                    rr_last_nxt = 1'b1;
                    rs_nxt      = req1_rs;
                    data_nxt    = req1_data;
                    long_nxt    = is_long_cmd(req1_rs, req1_data);
                end
            end
            default: begin
                state_nxt = S_PWRUP;
                cnt_nxt   = PWRUP_M1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_PWRUP;
            cnt         <= PWRUP_M1;
            init_idx    <= 3'd0;
            init_done_q <= 1'b0;
            rr_last     <= 1'b1;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            long_q      <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            init_idx    <= init_idx_nxt;
            init_done_q <= init_done_nxt;
            rr_last     <= rr_last_nxt;
            rs_q        <= rs_nxt;
            data_q      <= data_nxt;
            long_q      <= long_nxt;
            en_q        <= (state_nxt == S_PULSE);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = !idle_open;
    assign init_done  = init_done_q;
    assign LCD_RS     = rs_q;
    assign LCD_EN     = en_q;
    assign LCD_RW     = 1'b0;
    assign LCD_DATA   = data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Randomized and directed stimulus for lcd_bus_arbiter, checked every cycle
// against a timeline model of planned bus writes.
module tb_lcd_bus_arbiter;

    localparam int P = 20;
    localparam int S = 2;
    localparam int E = 3;
    localparam int X = 10;
    localparam int L = 40;
    localparam int G = 30;

    logic       CLK, RST;
    logic       req0_valid, req0_rs, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_rs, req1_ready;
    logic [7:0] req1_data;
    logic       busy, init_done, LCD_RS, LCD_EN, LCD_RW;
    logic [7:0] LCD_DATA;

    lcd_bus_arbiter #(
        .PWRUP_CYC(P), .SETUP_CYC(S), .EN_HIGH_CYC(E),
        .EXEC_CYC(X), .LONG_CYC(L), .INIT_GAP_CYC(G)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .busy(busy), .init_done(init_done),
        .LCD_RS(LCD_RS), .LCD_EN(LCD_EN), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       rs;
        logic [7:0] d;
    } item_t;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         s;
    } wr_t;

    item_t      q0[$];
    item_t      q1[$];
    wr_t        wq[$];
    logic [7:0] pulse_log[$];
    int         acc0_cyc[$];
    int         acc1_cyc[$];
    logic [7:0] init_tab[8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

    int   cyc, init_end, m_free, en_rises;
    int   n_tests, n_fail;
    logic m_rr, en_prev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int init_wait(input int k);
        return (k == 0) ? G : ((k == 5) ? L : X);
    endfunction

    task automatic model_reset();
        wr_t w;
        int  s;
        wq.delete();
        s = P;
        for (int k = 0; k < 8; k++) begin
            w.rs = 1'b0;
            w.d  = init_tab[k];
            w.s  = s;
            wq.push_back(w);
            s += S + E + init_wait(k);
        end
        init_end = s;
        m_free   = s;
        m_rr     = 1'b1;
        cyc      = 0;
        en_prev  = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the next cycle.
    task automatic step();
        logic       g0, g1, idle, exp_done, exp_en, exp_rs;
        logic [7:0] exp_d;
        item_t      it;
        wr_t        w;
        int         wt;
        req0_valid = (q0.size() > 0);
        req0_rs    = req0_valid ? q0[0].rs : 1'b0;
        req0_data  = req0_valid ? q0[0].d : 8'h00;
        req1_valid = (q1.size() > 0);
        req1_rs    = req1_valid ? q1[0].rs : 1'b0;
        req1_data  = req1_valid ? q1[0].d : 8'h00;
        @(negedge CLK);
        while (wq.size() > 1 && wq[1].s <= cyc) void'(wq.pop_front());
        if (wq.size() > 0 && wq[0].s <= cyc) begin
            exp_rs = wq[0].rs;
            exp_d  = wq[0].d;
            exp_en = (cyc >= wq[0].s + S) && (cyc < wq[0].s + S + E);
        end else begin
            exp_rs = 1'b0;
            exp_d  = 8'h00;
            exp_en = 1'b0;
        end
        exp_done = (cyc >= init_end);
        idle     = exp_done && (cyc >= m_free);
        g0 = idle && req0_valid && (!req1_valid || m_rr);
        g1 = idle && req1_valid && (!req0_valid || !m_rr);
        check_eq("init_done", init_done, exp_done);
        check_eq("busy", busy, !idle);
        check_eq("req0_ready", req0_ready, g0);
        check_eq("req1_ready", req1_ready, g1);
        check_eq("lcd_en", LCD_EN, exp_en);
        check_eq("lcd_rs", LCD_RS, exp_rs);
        check_eq("lcd_data", LCD_DATA, exp_d);
        check_eq("lcd_rw", LCD_RW, 1'b0);
        if (LCD_EN && !en_prev) begin
            en_rises++;
            pulse_log.push_back(LCD_DATA);
        end
        en_prev = LCD_EN;
        if (req0_valid && req0_ready) acc0_cyc.push_back(cyc);
        if (req1_valid && req1_ready) acc1_cyc.push_back(cyc);
        if (g0 || g1) begin
            if (g0) begin
                it = q0[0];
                void'(q0.pop_front());
            end else begin
                it = q1[0];
                void'(q1.pop_front());
            end
            m_rr = g1;
            w.rs = it.rs;
            w.d  = it.d;
            w.s  = cyc + 1;
            wt   = (!it.rs && it.d >= 8'd1 && it.d <= 8'd3) ? L : X;
            m_free = cyc + 1 + S + E + wt;
            wq.push_back(w);
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        check_eq("rst_en", LCD_EN, 1'b0);
        check_eq("rst_init_done", init_done, 1'b0);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_ready0", req0_ready, 1'b0);
        check_eq("rst_ready1", req1_ready, 1'b0);
        check_eq("rst_rs", LCD_RS, 1'b0);
        check_eq("rst_data", LCD_DATA, 8'h00);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && (q0.size() > 0 || q1.size() > 0); i++) step();
        repeat (60) step();
        check_eq(tag, q0.size() + q1.size(), 0);
    endtask

    initial begin
        item_t it;
        n_tests = 0;
        n_fail = 0;
        en_rises = 0;
        cyc = 0;
        req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
        RST = 1'b1;
        do_reset();

        // Init with no requesters active.
        en_rises = 0;
        pulse_log.delete();
        while (cyc < init_end + 5) step();
        check_eq("init_pulse_count", en_rises, 8);
        for (int k = 0; k < 8; k++) check_eq("init_byte", pulse_log[k], init_tab[k]);

        // Both requesters continuously valid: strict alternation starting with req0.
        pulse_log.delete();
        for (int k = 0; k < 4; k++) begin
            it.rs = 1'b1; it.d = 8'h30; q0.push_back(it);
            it.rs = 1'b1; it.d = 8'h31; q1.push_back(it);
        end
        drain("alt_drained");
        for (int k = 0; k < 8; k++) check_eq("alt_byte", pulse_log[k], (k % 2 == 1) ? 8'h31 : 8'h30);

        // req0 alone right after its own grant is served again without stalling.
        acc0_cyc.delete();
        it.rs = 1'b1; it.d = 8'h61; q0.push_back(it);
        it.rs = 1'b1; it.d = 8'h62; q0.push_back(it);
        drain("solo_drained");
        check_eq("solo_accepts", acc0_cyc.size(), 2);
        check_eq("solo_gap", acc0_cyc[1] - acc0_cyc[0], S + E + X + 1);

        // Long-wait decode on commands 0x01/0x02, short on 0x80 and on char 0x01.
        acc1_cyc.delete();
        it.rs = 1'b0; it.d = 8'h01; q1.push_back(it);
        it.rs = 1'b0; it.d = 8'h02; q1.push_back(it);
        it.rs = 1'b0; it.d = 8'h80; q1.push_back(it);
        it.rs = 1'b1; it.d = 8'h01; q1.push_back(it);
        it.rs = 1'b1; it.d = 8'h20; q1.push_back(it);
        drain("cmd_drained");
        check_eq("cmd_gap_01", acc1_cyc[1] - acc1_cyc[0], S + E + L + 1);
        check_eq("cmd_gap_02", acc1_cyc[2] - acc1_cyc[1], S + E + L + 1);
        check_eq("cmd_gap_80", acc1_cyc[3] - acc1_cyc[2], S + E + X + 1);
        check_eq("char_gap_01", acc1_cyc[4] - acc1_cyc[3], S + E + X + 1);

        // Request raised during init waits for init_done.
        do_reset();
        acc0_cyc.delete();
        pulse_log.delete();
        repeat (5) step();
        it.rs = 1'b1; it.d = 8'h41; q0.push_back(it);
        drain("during_init_drained");
        check_eq("during_init_accept_cyc", acc0_cyc[0], P + 8 * (S + E) + G + L + 6 * X);
        check_eq("during_init_byte", pulse_log[8], 8'h41);

        // Reset in the middle of a request pulse; req1's held byte survives.
        acc0_cyc.delete();
        it.rs = 1'b1; it.d = 8'h55; q0.push_back(it);
        for (int i = 0; i < 200 && acc0_cyc.size() == 0; i++) step();
        check_eq("mid_rst_accepted", acc0_cyc.size(), 1);
        it.rs = 1'b1; it.d = 8'h66; q1.push_back(it);
        for (int i = 0; i < 20 && cyc < acc0_cyc[0] + S + 2; i++) step();
        check_eq("mid_rst_en_before", LCD_EN, 1'b1);
        do_reset();
        acc1_cyc.delete();
        pulse_log.delete();
        drain("mid_rst_drained");
        check_eq("mid_rst_accepts", acc1_cyc.size(), 1);
        check_eq("mid_rst_accept_cyc", acc1_cyc[0], P + 8 * (S + E) + G + L + 6 * X);
        check_eq("mid_rst_pulses", pulse_log.size(), 9);
        check_eq("mid_rst_byte", pulse_log[8], 8'h66);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 5) == 0) begin
                it.rs = 1'($urandom_range(0, 1));
                it.d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
                q0.push_back(it);
            end
            if (q1.size() == 0 && $urandom_range(0, 5) == 0) begin
                it.rs = 1'($urandom_range(0, 1));
                it.d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
                q1.push_back(it);
            end
            step();
        end
        drain("random_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
